// File: rtl/inst_queue.sv
// Instruction prefetch queue: circular FIFO of {PC, instruction} pairs between
// fetch and decode, with MIPS field pre-split on the head and single-cycle flush.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_addr,
    input  logic [WIDTH-1:0]         in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_addr,
    output logic [WIDTH-1:0]         out_inst,
    output logic [5:0]               out_op,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [4:0]               out_rd,
    output logic [15:0]              out_imm,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wp;
    logic [AW-1:0]      rp;
    logic               push;
    logic               pop;

    // in_ready is a function of count alone, so out_ready never reaches it.
    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the pointers and occupancy are discarded.
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= {in_addr, in_inst};
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_addr = '0;
        out_inst = '0;
        if (out_valid) begin
            out_addr = mem[rp][2*WIDTH-1:WIDTH];
            out_inst = mem[rp][WIDTH-1:0];
        end
    end

    assign out_op  = out_inst[31:26];
    assign out_rs  = out_inst[25:21];
    assign out_rt  = out_inst[20:16];
    assign out_rd  = out_inst[15:11];
    assign out_imm = out_inst[15:0];

endmodule
